// File: rtl/msu_pkg.sv
// Shared constants and state encoding for the MSU sector-read handshake.
// Requester and responder blocks both import this package.
package msu_pkg;

    localparam int unsigned SECTOR_WORDS = 256;
    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned WORD_IDX_W   = 8;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned SECTOR_CNT_W = 24;
    localparam int unsigned GAP_W        = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        GAP,
        DONE
    } sr_state_t;

endpackage

// File: rtl/msu_sector_responder_if.sv
// Sector-read handshake plus image-memory port.
// slave  : responder side (answers sd_rd, issues mem_rd).
// master : requester + memory side (drives sd_rd/sd_lba, returns mem data).
interface msu_sector_responder_if
    import msu_pkg::*;
#(
    parameter int unsigned LBA_W  = 21,
    parameter int unsigned MEM_AW = 24
);

    logic                  sd_rd;
    logic [LBA_W-1:0]      sd_lba;
    logic                  sd_ack;
    logic [WORD_IDX_W-1:0] sd_buff_addr;
    logic [DATA_W-1:0]     sd_buff_dout;
    logic                  sd_buff_wr;
    logic                  mem_rd;
    logic [MEM_AW-1:0]     mem_addr;
    logic                  mem_valid;
    logic [DATA_W-1:0]     mem_dout;
    logic                  oor;

    modport slave (
        input  sd_rd, sd_lba, mem_valid, mem_dout,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_rd, mem_addr, oor
    );

    modport master (
        output sd_rd, sd_lba, mem_valid, mem_dout,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_rd, mem_addr, oor
    );

endinterface

// File: rtl/msu_sector_responder.sv
// Responder for the MSU sector-read handshake: acknowledges sd_rd, then
// streams one 512-byte sector as 256 word strobes fetched from image memory
// (or zeros when the LBA lies beyond the mounted image).
// Ports: clk, reset_n (async active-low), img_mounted/img_size (image size
// latch), bus (slave modport: sd_* handshake, mem_* fetch port, oor pulse).
module msu_sector_responder
    import msu_pkg::*;
#(
    parameter int unsigned LBA_W  = 21,
    parameter int unsigned MEM_AW = 24,
    parameter int unsigned WR_GAP = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  img_mounted,
    input  logic [31:0]           img_size,
    msu_sector_responder_if.slave bus
);

    localparam int unsigned CMP_W   = (LBA_W > SECTOR_CNT_W) ? LBA_W : SECTOR_CNT_W;
    localparam int unsigned BYTE_SH = $clog2(SECTOR_BYTES);
    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(SECTOR_WORDS - 1);
    localparam logic [GAP_W-1:0]      GAP_INIT = GAP_W'((WR_GAP == 0) ? 0 : WR_GAP - 1);

    sr_state_t             state_q, state_d;
    logic [LBA_W-1:0]      lba_q, lba_d;
    logic                  in_range_q, in_range_d;
    logic [WORD_IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [SECTOR_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic                  ack_q, ack_d;
    logic                  wr_q, wr_d;
    logic [WORD_IDX_W-1:0] baddr_q, baddr_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
    logic                  oor_q, oor_d;

    logic [32:0]           size_round;
    logic                  req_in_range;

    // Round the byte size up to whole sectors; 33 bits so 0xFFFFFFFF cannot wrap.
    assign size_round   = {1'b0, img_size} + 33'(SECTOR_BYTES - 1);
    assign req_in_range = CMP_W'(bus.sd_lba) < CMP_W'(sec_cnt_q);

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lba_q      <= '0;
            in_range_q <= 1'b0;
            idx_q      <= '0;
            gap_q      <= '0;
            sec_cnt_q  <= '0;
            ack_q      <= 1'b0;
            wr_q       <= 1'b0;
            baddr_q    <= '0;
            dout_q     <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lba_q      <= lba_d;
            in_range_q <= in_range_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            sec_cnt_q  <= sec_cnt_d;
            ack_q      <= ack_d;
            wr_q       <= wr_d;
            baddr_q    <= baddr_d;
            dout_q     <= dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            oor_q      <= oor_d;
        end
    end

    // Next state; outputs are computed one cycle early so they leave registered.
    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        in_range_d = in_range_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        ack_d      = ack_q;
        wr_d       = 1'b0;
        baddr_d    = baddr_q;
        dout_d     = dout_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        oor_d      = 1'b0;
        sec_cnt_d  = img_mounted ? SECTOR_CNT_W'(size_round >> BYTE_SH) : sec_cnt_q;

        unique case (state_q)
            // DONE accepts like IDLE so back-to-back sectors see ack low for one cycle.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.sd_rd) begin
                    state_d    = FETCH;
                    lba_d      = bus.sd_lba;
                    in_range_d = req_in_range;
                    idx_d      = '0;
                    ack_d      = 1'b1;
                    oor_d      = !req_in_range;
                    mem_rd_d   = req_in_range;
                    if (req_in_range) begin
                        mem_addr_d = MEM_AW'({bus.sd_lba, WORD_IDX_W'(0)});
                    end
                end
            end
            FETCH: begin
                if (in_range_q) begin
                    state_d = WAIT;
                end else begin
                    state_d = WRITE;
                    dout_d  = '0;
                    wr_d    = 1'b1;
                    baddr_d = idx_q;
                end
            end
            WAIT: begin
                if (bus.mem_valid) begin
                    state_d = WRITE;
                    dout_d  = bus.mem_dout;
                    wr_d    = 1'b1;
                    baddr_d = idx_q;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    ack_d   = 1'b0;
                    baddr_d = '0;
                end else begin
                    idx_d = idx_q + WORD_IDX_W'(1);
                    if (WR_GAP == 0) begin
                        state_d  = FETCH;
                        mem_rd_d = in_range_q;
                        if (in_range_q) begin
                            mem_addr_d = MEM_AW'({lba_q, idx_q + WORD_IDX_W'(1)});
                        end
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d  = FETCH;
                    mem_rd_d = in_range_q;
                    if (in_range_q) begin
                        mem_addr_d = MEM_AW'({lba_q, idx_q});
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_wr   = wr_q;
    assign bus.sd_buff_addr = baddr_q;
    assign bus.sd_buff_dout = dout_q;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.oor          = oor_q;

endmodule

// File: tb/tb_msu_sector_responder.sv
// Bench for msu_sector_responder: table of sector requests, hand-written
// corner sequences (reset mid-sector, back-to-back, remount mid-sector) and
// random requests checked against a sector/byte arithmetic model.
module tb_msu_sector_responder;
    import msu_pkg::*;

    localparam int unsigned LBA_W  = 21;
    localparam int unsigned MEM_AW = 24;
    localparam int unsigned WR_GAP = 1;

    logic        clk;
    logic        reset_n;
    logic        img_mounted;
    logic [31:0] img_size;
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    int          n_cmp = 0;
    int          n_err = 0;
    int          overlap_err = 0;

    msu_sector_responder_if #(.LBA_W(LBA_W), .MEM_AW(MEM_AW)) bus ();

    msu_sector_responder #(.LBA_W(LBA_W), .MEM_AW(MEM_AW), .WR_GAP(WR_GAP)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Image memory contents: a fixed hash of the word address.
    function automatic logic [15:0] pattern(input logic [MEM_AW-1:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'd2654435761;
        return x[31:16] ^ x[15:0];
    endfunction

    // Word w of sector lba lives at lba*256 + w, wrapped to the memory size.
    function automatic logic [MEM_AW-1:0] model_addr(input int unsigned lba, input int unsigned w);
        longint unsigned full;
        full = 64'(lba) * 64'(SECTOR_WORDS) + 64'(w);
        return MEM_AW'(full % (64'd1 << MEM_AW));
    endfunction

    // A sector exists if its first byte lies inside the image.
    function automatic logic model_in_range(input logic [31:0] size, input int unsigned lba);
        return (64'(lba) * 64'd512) < 64'(size);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: answers each mem_rd after mem_lat cycles, junk on mem_dout otherwise.
    logic              pend = 1'b0;
    int unsigned       pcnt = 0;
    logic [MEM_AW-1:0] paddr = '0;
    always @(negedge clk) begin
        bus.mem_valid = 1'b0;
        bus.mem_dout  = 16'($urandom);
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                pcnt = pcnt - 1;
                if (pcnt == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_dout  = pattern(paddr);
                    pend = 1'b0;
                end
            end
            if (bus.mem_rd) begin
                if (pend) overlap_err++;
                pend  = 1'b1;
                pcnt  = mem_lat;
                paddr = bus.mem_addr;
            end
        end
    end

    task automatic mount(input logic [31:0] size);
        @(negedge clk);
        img_size    = size;
        img_mounted = 1'b1;
        @(negedge clk);
        img_mounted = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},      64'(bus.sd_ack), 64'd0);
        check({tag, "_wr"},       64'(bus.sd_buff_wr), 64'd0);
        check({tag, "_mem_rd"},   64'(bus.mem_rd), 64'd0);
        check({tag, "_oor"},      64'(bus.oor), 64'd0);
        check({tag, "_addr"},     64'(bus.sd_buff_addr), 64'd0);
        check({tag, "_dout"},     64'(bus.sd_buff_dout), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    endtask

    // One full sector request with per-word timing, address and data checks.
    task automatic run_sector(input int unsigned lba, input logic exp_inr, input int unsigned lat,
                              input bit pre_raised, input int mount_at, input logic [31:0] mount_sz,
                              input bit chain_next, input int unsigned next_lba,
                              output logic oor1, output logic [MEM_AW-1:0] addr1);
        int unsigned c1, t_exp, period, budget, nstrobe, nrd, oor_extra, ack_drop, hold_bad;
        logic [15:0] exp_d, last_d;
        bit done, mounted;
        mem_lat = lat;
        if (!pre_raised) begin
            @(negedge clk);
            bus.sd_rd  = 1'b1;
            bus.sd_lba = LBA_W'(lba);
        end
        @(negedge clk);
        c1    = cyc;
        oor1  = bus.oor;
        addr1 = bus.mem_addr;
        check("ack_cycle1", 64'(bus.sd_ack), 64'd1);
        check("oor_cycle1", 64'(bus.oor), 64'(!exp_inr));
        check("mem_rd_cycle1", 64'(bus.mem_rd), 64'(exp_inr));
        nrd = exp_inr ? 1 : 0;
        if (exp_inr) check("mem_addr_w0", 64'(bus.mem_addr), 64'(model_addr(lba, 0)));
        bus.sd_rd  = 1'b0;
        bus.sd_lba = LBA_W'($urandom);
        period  = (exp_inr ? lat : 0) + 2 + WR_GAP;
        t_exp   = c1 + (exp_inr ? lat : 0) + 1;
        budget  = SECTOR_WORDS * period + 20;
        nstrobe = 0; oor_extra = 0; ack_drop = 0; hold_bad = 0;
        done = 1'b0; mounted = 1'b0; last_d = '0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (img_mounted) img_mounted = 1'b0;
            if (mount_at >= 0 && !mounted && nstrobe == 32'(mount_at)) begin
                img_size    = mount_sz;
                img_mounted = 1'b1;
                mounted     = 1'b1;
            end
            if (bus.mem_rd) begin
                nrd++;
                check("mem_addr", 64'(bus.mem_addr), 64'(model_addr(lba, nstrobe)));
            end
            if (bus.oor) oor_extra++;
            if (!bus.sd_ack) ack_drop++;
            if (bus.sd_buff_wr) begin
                exp_d = exp_inr ? pattern(model_addr(lba, nstrobe)) : 16'h0;
                check("strobe_cycle", 64'(cyc - c1), 64'(t_exp - c1));
                check("strobe_addr", 64'(bus.sd_buff_addr), 64'(nstrobe));
                check("strobe_data", 64'(bus.sd_buff_dout), 64'(exp_d));
                last_d  = exp_d;
                nstrobe = nstrobe + 1;
                t_exp   = t_exp + period;
                if (nstrobe == SECTOR_WORDS) done = 1'b1;
            end else if (nstrobe > 0) begin
                if (bus.sd_buff_addr != 8'(nstrobe - 1) || bus.sd_buff_dout != last_d) hold_bad++;
            end
        end
        check("sector_complete", 64'(nstrobe), 64'(SECTOR_WORDS));
        check("mem_rd_count", 64'(nrd), 64'(exp_inr ? SECTOR_WORDS : 0));
        check("oor_extra", 64'(oor_extra), 64'd0);
        check("ack_held", 64'(ack_drop), 64'd0);
        check("out_hold", 64'(hold_bad), 64'd0);
        @(negedge clk);
        img_mounted = 1'b0;
        check("ack_low_T1", 64'(bus.sd_ack), 64'd0);
        check("addr_zero_T1", 64'(bus.sd_buff_addr), 64'd0);
        if (chain_next) begin
            bus.sd_rd  = 1'b1;
            bus.sd_lba = LBA_W'(next_lba);
        end
    endtask

    typedef struct {
        logic [31:0]       size;
        int unsigned       lba;
        int unsigned       lat;
        logic              exp_oor;
        logic [MEM_AW-1:0] exp_addr0;
    } vec_t;

    initial begin
        vec_t              vecs[11];
        logic              o1;
        logic [MEM_AW-1:0] a1;
        logic [31:0]       rsz;
        int unsigned       rlba, rlat;
        bit                seen;

        vecs[0]  = '{32'd1024,       1,         2, 1'b0, 24'd256};
        vecs[1]  = '{32'd1024,       2,         2, 1'b1, 24'd0};
        vecs[2]  = '{32'd1100,       2,         3, 1'b0, 24'd512};
        vecs[3]  = '{32'd512,        0,         1, 1'b0, 24'd0};
        vecs[4]  = '{32'd511,        0,         1, 1'b0, 24'd0};
        vecs[5]  = '{32'd513,        1,         4, 1'b0, 24'd256};
        vecs[6]  = '{32'd512,        1,         1, 1'b1, 24'd0};
        vecs[7]  = '{32'd0,          0,         1, 1'b1, 24'd0};
        vecs[8]  = '{32'hFFFF_FFFF,  21'h1FFFFF, 1, 1'b0, 24'hFFFF00};
        vecs[9]  = '{32'h0400_0000,  21'h1FFFF,  1, 1'b0, 24'hFFFF00};
        vecs[10] = '{32'h0400_0000,  21'h20000,  1, 1'b1, 24'd0};

        reset_n       = 1'b0;
        img_mounted   = 1'b0;
        img_size      = '0;
        bus.sd_rd     = 1'b0;
        bus.sd_lba    = '0;
        bus.mem_valid = 1'b0;
        bus.mem_dout  = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 11; i++) begin
            mount(vecs[i].size);
            run_sector(vecs[i].lba, !vecs[i].exp_oor, vecs[i].lat, 1'b0, -1, '0, 1'b0, 0, o1, a1);
            check($sformatf("vec%0d_oor", i), 64'(o1), 64'(vecs[i].exp_oor));
            if (!vecs[i].exp_oor) check($sformatf("vec%0d_addr0", i), 64'(a1), 64'(vecs[i].exp_addr0));
        end

        // Reset in the middle of word 100, then a fresh sector from word 0.
        mount(32'd4096);
        mem_lat = 2;
        @(negedge clk);
        bus.sd_rd  = 1'b1;
        bus.sd_lba = LBA_W'(3);
        @(negedge clk);
        bus.sd_rd = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (bus.sd_buff_wr && bus.sd_buff_addr == 8'd99) seen = 1'b1;
        end
        check("reach_word99", 64'(seen), 64'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mount(32'd4096);
        run_sector(0, 1'b1, 2, 1'b0, -1, '0, 1'b0, 0, o1, a1);
        check("after_reset_addr0", 64'(a1), 64'd0);

        // Back-to-back: next request raised in the cycle after the last strobe.
        mount(32'd1024);
        run_sector(1, 1'b1, 1, 1'b0, -1, '0, 1'b1, 0, o1, a1);
        run_sector(0, 1'b1, 2, 1'b1, -1, '0, 1'b0, 0, o1, a1);
        check("chain_addr0", 64'(a1), 64'd0);

        // Unmount (size 0) at word 50: sector finishes from memory, next is out of range.
        mount(32'd2048);
        run_sector(0, 1'b1, 1, 1'b0, 50, 32'd0, 1'b0, 0, o1, a1);
        run_sector(0, 1'b0, 1, 1'b0, -1, '0, 1'b0, 0, o1, a1);
        check("unmount_oor", 64'(o1), 64'd1);

        // Random sizes, sectors and memory latencies.
        for (int i = 0; i < 6; i++) begin
            rsz  = 32'($urandom_range(0, 5000));
            rlba = $urandom_range(0, 10);
            rlat = $urandom_range(1, 4);
            mount(rsz);
            run_sector(rlba, model_in_range(rsz, rlba), rlat, 1'b0, -1, '0, 1'b0, 0, o1, a1);
        end

        check("single_outstanding", 64'(overlap_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
